spi_slave_shifter: RTL and testbench
====================================

Name: spi_slave_shifter

Overview:
Slave-side counterpart of the SPI master clock and shift path. It receives an externally driven SCLK, SS and MOSI, synchronises them into the PClk domain, and decodes the sample and drive edges from cpol/cpha. It deserialises MOSI into rx_data and serialises a buffered tx byte onto MISO. It sits beside the APB register block, which reads rx_data and writes tx_data when the SPI is configured as a slave.

Parameters:
DATA_WIDTH, 8, frame length in bits (≥2)
SYNC_STAGES, 2, flops per input synchroniser (≥2)

Ports:
PClk  input  1  system clock; all logic is on the rising edge
PRESET  input  1  asynchronous, active-high reset
slave_en  input  1  block enabled (SPE=1, MSTR=0, spi_mode 00 or 01, not (spiswai and wait mode))
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
lsbfe  input  1  1: LSB first on both MOSI and MISO
sclk_in  input  1  asynchronous SCLK from master
ss_n  input  1  asynchronous slave select, active-low
mosi  input  1  asynchronous serial data in
miso  output  1  serial data out
miso_oe  output  1  MISO output enable
tx_data  input  DATA_WIDTH  byte to transmit
tx_load  input  1  one-cycle write strobe for tx_data
tx_empty  output  1  tx buffer free
rx_data  output  DATA_WIDTH  last complete received frame
rx_full  output  1  rx_data holds unread data (SPIF)
rx_read  input  1  one-cycle read-acknowledge strobe
overrun  output  1  sticky overrun flag
busy  output  1  frame in progress

Behaviour:
- Reset (async, PRESET=1): all synchroniser flops take their idle values (sclk=cpol, ss=1, mosi=0). rx_data=0, rx_full=0, overrun=0, tx_empty=1, busy=0, miso=0, miso_oe=0, bit counter=0, state=IDLE.
- Synchronisers: SYNC_STAGES flops each on sclk_in, ss_n and mosi. An extra flop holds the previous synchronised sclk.
  - rise = s & ~prev; fall = ~s & prev.
  - lead = cpol ? fall : rise; trail = the other edge.
  - sample = cpha ? trail : lead; drive = cpha ? lead : trail.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 PClk periods. Behaviour for faster SCLK is undefined.
- FSM, states IDLE and ACTIVE:
  - IDLE→ACTIVE when the synchronised ss goes low and slave_en=1. On this transition: tx shift register ← tx buffer (or all-ones if tx_empty=1), tx_empty←1, counter←0, first_flag←1.
  - ACTIVE→IDLE when the synchronised ss goes high or slave_en=0. The partial frame is discarded: no rx_full, counter←0.
  - busy=1 in ACTIVE. miso_oe = ACTIVE.
- Sample edge: rx shift ← mosi inserted at the LSB end (lsbfe=0) or the MSB end (lsbfe=1); counter++.
- Counter reaching DATA_WIDTH (the wrap):
  - If rx_full=0, or rx_read is asserted in the same cycle: rx_data←assembled word and rx_full←1.
  - Otherwise: rx_data is unchanged, the new word is lost, overrun←1.
  - counter←0, first_flag←1.
- Drive edge:
  - cpha=0: on the trailing edge after a wrap, reload the tx shift register from the buffer (or all-ones); otherwise shift.
  - cpha=1: the first leading edge of a frame clears first_flag without shifting. On the trailing edge of a wrap, reload as above.
  - A reload consumes the buffer and sets tx_empty←1.
- miso = tx shift MSB (lsbfe=0) or LSB (lsbfe=1), registered. Outside ACTIVE it holds 0.
- tx_load:
  - When tx_empty=1: buffer←tx_data, tx_empty←0.
  - When tx_empty=0: ignored, buffer unchanged.
  - tx_load in the same cycle as a reload: the reload takes the old buffer contents, then the new data is stored and tx_empty←0.
- rx_read clears rx_full and overrun. overrun is not cleared by any other event except reset.
- Latency: rx_full rises SYNC_STAGES+2 PClk edges after the last-bit SCLK transition meets setup at the first synchroniser flop.
- Mode changes (cpol, cpha, lsbfe) while busy=1 are unsupported. The block holds its state until SS deasserts.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_MODE_RUN=2'b00, SPI_MODE_WAIT=2'b01, SPI_MODE_STOP=2'b10
  - the slave FSM state type (IDLE, ACTIVE)
  - the DATA_WIDTH default
- Sub-module spi_sync_edge contains the synchroniser chain for sclk/ss/mosi plus the rise/fall detect. It is shared with the master for its SS fault input.

Test Plan:
- Mode 0 (cpol=0, cpha=0, lsbfe=0), tx_load 0x3C, master sends 0xA5 → rx_data=0xA5, rx_full=1 once, MISO bits sampled by the master = 0x3C, tx_empty=1 after frame start.
- Mode 3 with lsbfe=1, tx 0x81, master sends 0x0F LSB-first → rx_data=0x0F, master receives 0x81, first leading edge does not shift.
- Two back-to-back frames with SS held low and no rx_read, sending 0x11 then 0x22 → rx_data=0x11, overrun=1; rx_read → rx_full=0, overrun=0.
- SS deasserted after 5 bits, then a full frame 0x5A → no rx_full after the partial frame, rx_data=0x5A after the full one, counter restarts at 0.
- tx buffer never loaded, master sends 0x00 → MISO frame=0xFF, rx_data=0x00.
- PRESET pulsed mid-frame, then a full frame 0xC3 → all outputs at reset values immediately, next frame received correctly as 0xC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: operating-mode encodings, slave FSM state type and
// the default frame width used by both the master and slave shift paths.
package spi_pkg;

    localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
    localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
    localparam logic [1:0] SPI_MODE_STOP = 2'b10;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic {
        SLV_IDLE   = 1'b0,
        SLV_ACTIVE = 1'b1
    } slave_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings SCLK, SS and MOSI into the system clock domain and produces registered
// one-cycle SCLK rise/fall pulses. Each chain resets to the line's idle level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpol_i,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic ss_o,
    output logic mosi_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] async_in;
    logic [2:0] idle_val;
    logic [2:0] sync_out;

    assign async_in = {mosi_i, ss_n_i, sclk_i};
    assign idle_val = {1'b0, 1'b1, cpol_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [STAGES-1:0] chain_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    chain_q <= {STAGES{idle_val[gi]}};
                end else begin
                    chain_q <= {chain_q[STAGES-2:0], async_in[gi]};
                end
            end

            assign sync_out[gi] = chain_q[STAGES-1];
        end
    endgenerate

    logic sclk_prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_prev_q <= cpol_i;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sync_out[0];
            rise_q      <= sync_out[0] & ~sclk_prev_q;
            fall_q      <= ~sync_out[0] & sclk_prev_q;
        end
    end

    assign ss_o   = sync_out[1];
    assign mosi_o = sync_out[2];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave shift path: decodes sample/drive edges from cpol/cpha, deserialises
// MOSI into rx_data and serialises a single-entry tx buffer onto MISO.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PClk,
    input  logic                  PRESET,
    input  logic                  slave_en,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic                  sclk_in,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_full,
    input  logic                  rx_read,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic ss_s, mosi_s, sclk_rise, sclk_fall;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (PClk),
        .rst_i  (PRESET),
        .cpol_i (cpol),
        .sclk_i (sclk_in),
        .ss_n_i (ss_n),
        .mosi_i (mosi),
        .ss_o   (ss_s),
        .mosi_o (mosi_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    logic lead_edge, trail_edge, sample_edge, drive_edge;

    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign drive_edge  = cpha ? lead_edge : trail_edge;

    slave_state_e          state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_word;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_full_q, rx_full_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_empty_q, tx_empty_d;
    logic                  miso_q, miso_d;
    logic                  reload;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_full_d  = rx_full_q;
        overrun_d  = overrun_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        reload     = 1'b0;
        cnt_inc    = cnt_q + CW'(1);
        rx_word    = lsbfe ? {mosi_s, rx_shift_q[DATA_WIDTH-1:1]}
                           : {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

        // A read is overridden below when a new word lands in the same cycle.
        if (rx_read) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            SLV_IDLE: begin
                if (!ss_s && slave_en) begin
                    state_d = SLV_ACTIVE;
                    reload  = 1'b1;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end
            SLV_ACTIVE: begin
                if (ss_s || !slave_en) begin
                    state_d = SLV_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_word;
                        if (cnt_inc == CW'(DATA_WIDTH)) begin
                            cnt_d   = '0;
                            first_d = 1'b1;
                            if (!rx_full_q || rx_read) begin
                                rx_data_d = rx_word;
                                rx_full_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                            // With cpha=1 the wrapping sample edge is also the trailing edge.
                            if (cpha) begin
                                reload = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    if (drive_edge) begin
                        // A leading edge always precedes a trailing one, so cnt==0 here means a wrap.
                        if (!cpha && cnt_q == '0) begin
                            reload = 1'b1;
                        end else if (cpha && first_q) begin
                            first_d = 1'b0;
                        end else begin
                            tx_shift_d = lsbfe ? {1'b0, tx_shift_q[DATA_WIDTH-1:1]}
                                               : {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = SLV_IDLE;
        endcase

        if (reload) begin
            tx_shift_d = tx_empty_q ? '1 : tx_buf_q;
            tx_empty_d = 1'b1;
        end
        if (tx_load && (tx_empty_q || reload)) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end

        miso_d = (state_d == SLV_ACTIVE) ?
                 (lsbfe ? tx_shift_d[0] : tx_shift_d[DATA_WIDTH-1]) : 1'b0;
    end

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= SLV_IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_empty_q <= 1'b1;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_empty_q <= tx_empty_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == SLV_ACTIVE);
    assign busy     = (state_q == SLV_ACTIVE);
    assign tx_empty = tx_empty_q;
    assign rx_data  = rx_data_q;
    assign rx_full  = rx_full_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: an SPI master model drives SCLK/SS/MOSI and a
// frame-level reference model predicts rx_data, flags and the MISO byte.
module tb_spi_slave_shifter;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic         PClk = 1'b0;
    logic         PRESET, slave_en, cpol, cpha, lsbfe;
    logic         sclk_in, ss_n, mosi, miso, miso_oe;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_load, tx_empty, rx_full, rx_read, overrun, busy;

    always #5 PClk = ~PClk;

    spi_slave_shifter #(
        .DATA_WIDTH  (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .PClk     (PClk),
        .PRESET   (PRESET),
        .slave_en (slave_en),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsbfe    (lsbfe),
        .sclk_in  (sclk_in),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_empty (tx_empty),
        .rx_data  (rx_data),
        .rx_full  (rx_full),
        .rx_read  (rx_read),
        .overrun  (overrun),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: one-entry tx buffer and the received-word register.
    logic [W-1:0] m_buf;
    bit           m_buf_v;
    logic [W-1:0] m_rx;
    bit           m_full;
    bit           m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge PClk);
    endtask

    task automatic model_reset();
        m_buf = '0; m_buf_v = 0; m_rx = '0; m_full = 0; m_ov = 0;
    endtask

    // Frame start and every completed frame each take the buffer (all-ones if empty).
    task automatic model_take(output logic [W-1:0] v);
        v = m_buf_v ? m_buf : '1;
        m_buf_v = 0;
    endtask

    task automatic model_rx(input logic [W-1:0] b);
        if (!m_full) begin
            m_rx = b; m_full = 1;
        end else begin
            m_ov = 1;
        end
    endtask

    task automatic do_load(input logic [W-1:0] b);
        tx_data = b; tx_load = 1'b1;
        @(negedge PClk);
        tx_load = 1'b0;
        if (!m_buf_v) begin
            m_buf = b; m_buf_v = 1;
        end
        $display("load  tx=%02h buffered=%0d", b, m_buf_v);
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        @(negedge PClk);
        rx_read = 1'b0;
        m_full = 0; m_ov = 0;
        $display("read  rx_data=%02h", rx_data);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p; cpha = h; lsbfe = l; sclk_in = p;
        wait_cycles(12);
    endtask

    // Master side: shifts nbits of 'out' onto MOSI and captures MISO into 'in'.
    task automatic sclk_byte(input logic [W-1:0] out, input int nbits, output logic [W-1:0] in);
        in = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = lsbfe ? i : W - 1 - i;
            if (!cpha) begin
                mosi = out[idx];
                wait_cycles(HALF);
                sclk_in = ~cpol;
                in[idx] = miso;
                wait_cycles(HALF);
                sclk_in = cpol;
            end else begin
                sclk_in = ~cpol;
                mosi = out[idx];
                wait_cycles(HALF);
                sclk_in = cpol;
                in[idx] = miso;
                wait_cycles(HALF);
            end
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "/rx_data"}, rx_data, m_rx);
        check({tag, "/rx_full"}, rx_full, m_full);
        check({tag, "/overrun"}, overrun, m_ov);
        check({tag, "/tx_empty"}, tx_empty, !m_buf_v);
        check({tag, "/busy"}, busy, 1'b0);
        check({tag, "/miso_oe"}, miso_oe, 1'b0);
    endtask

    task automatic frame1(input string tag, input logic [W-1:0] mo);
        logic [W-1:0] exp_mi, got_mi, dummy;
        model_take(exp_mi);
        ss_n = 1'b0;
        wait_cycles(HALF);
        check({tag, "/busy_on"}, busy, 1'b1);
        check({tag, "/oe_on"}, miso_oe, 1'b1);
        check({tag, "/tx_empty_start"}, tx_empty, 1'b1);
        sclk_byte(mo, W, got_mi);
        model_rx(mo);
        model_take(dummy);
        wait_cycles(HALF);
        ss_n = 1'b1;
        wait_cycles(2 * HALF);
        check({tag, "/miso_frame"}, got_mi, exp_mi);
        check_rx(tag);
        $display("frame %s mode=%0d%0d lsbfe=%0d mosi=%02h miso=%02h rx=%02h full=%0d ovr=%0d",
                 tag, cpol, cpha, lsbfe, mo, got_mi, rx_data, rx_full, overrun);
    endtask

    initial begin
        logic [W-1:0] exp0, exp1, got0, got1, junk;

        PRESET = 1'b1; slave_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        sclk_in = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_load = 1'b0; rx_read = 1'b0;
        model_reset();
        wait_cycles(3);
        check("reset/rx_data", rx_data, '0);
        check("reset/rx_full", rx_full, 1'b0);
        check("reset/overrun", overrun, 1'b0);
        check("reset/tx_empty", tx_empty, 1'b1);
        check("reset/busy", busy, 1'b0);
        check("reset/miso", miso, 1'b0);
        check("reset/miso_oe", miso_oe, 1'b0);
        PRESET = 1'b0;
        wait_cycles(4);

        // Mode 0: second load while the buffer is full must be ignored.
        set_mode(1'b0, 1'b0, 1'b0);
        do_load(8'h3C);
        do_load(8'h99);
        check("m0/tx_empty_loaded", tx_empty, 1'b0);
        frame1("m0", 8'hA5);
        check("m0/rx_literal", rx_data, 8'hA5);

        // Mode 3, LSB first.
        do_read();
        set_mode(1'b1, 1'b1, 1'b1);
        do_load(8'h81);
        frame1("m3lsb", 8'h0F);
        check("m3lsb/rx_literal", rx_data, 8'h0F);

        // Back-to-back frames under one SS with no read in between.
        do_read();
        set_mode(1'b0, 1'b0, 1'b0);
        model_take(exp0);
        ss_n = 1'b0;
        wait_cycles(HALF);
        sclk_byte(8'h11, W, got0);
        model_rx(8'h11);
        model_take(exp1);
        sclk_byte(8'h22, W, got1);
        model_rx(8'h22);
        model_take(junk);
        wait_cycles(HALF);
        ss_n = 1'b1;
        wait_cycles(2 * HALF);
        check("b2b/miso0", got0, exp0);
        check("b2b/miso1", got1, exp1);
        check_rx("b2b");
        check("b2b/overrun_literal", overrun, 1'b1);
        $display("frame b2b rx=%02h full=%0d ovr=%0d", rx_data, rx_full, overrun);
        do_read();
        check("b2b/full_cleared", rx_full, m_full);
        check("b2b/ovr_cleared", overrun, m_ov);

        // SS deasserted after 5 bits: partial frame is dropped.
        model_take(junk);
        ss_n = 1'b0;
        wait_cycles(HALF);
        sclk_byte(8'hE7, 5, junk);
        wait_cycles(HALF);
        ss_n = 1'b1;
        wait_cycles(2 * HALF);
        check_rx("partial");
        $display("frame partial rx=%02h full=%0d", rx_data, rx_full);
        frame1("after_partial", 8'h5A);

        // Buffer never loaded: MISO sends all ones.
        do_read();
        frame1("noload", 8'h00);

        // PRESET pulsed mid-frame.
        do_load(8'h6E);
        ss_n = 1'b0;
        wait_cycles(HALF);
        sclk_byte(8'hFF, 4, junk);
        #3 PRESET = 1'b1;
        #1;
        check("midrst/rx_data", rx_data, '0);
        check("midrst/rx_full", rx_full, 1'b0);
        check("midrst/overrun", overrun, 1'b0);
        check("midrst/tx_empty", tx_empty, 1'b1);
        check("midrst/busy", busy, 1'b0);
        check("midrst/miso", miso, 1'b0);
        check("midrst/miso_oe", miso_oe, 1'b0);
        $display("reset mid-frame busy=%0d tx_empty=%0d", busy, tx_empty);
        ss_n = 1'b1;
        sclk_in = cpol;
        wait_cycles(3);
        PRESET = 1'b0;
        model_reset();
        wait_cycles(4);
        frame1("post_reset", 8'hC3);

        // Randomised frames in all four modes.
        for (int k = 0; k < 10; k++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
            if ($urandom_range(0, 2) != 0) do_read();
            frame1("rand", W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
